// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage sequencer: opcodes, FSM states,
// instruction field layout and opcode classification helpers.
package alu_pkg;

    localparam int OPC_W = 5;
    localparam int REG_W = 5;
    localparam int IMM_W = 17;

    // Field positions inside a 32-bit instruction word; dest and imm overlap.
    localparam int OPC_LSB  = 27;
    localparam int SRCA_LSB = 22;
    localparam int SRCB_LSB = 17;
    localparam int DEST_LSB = 12;
    localparam int IMM_LSB  = 0;

    localparam logic [OPC_W-1:0] OP_LW  = 5'd0;
    localparam logic [OPC_W-1:0] OP_SW  = 5'd1;
    localparam logic [OPC_W-1:0] OP_ADD = 5'd3;
    localparam logic [OPC_W-1:0] OP_SUB = 5'd4;
    localparam logic [OPC_W-1:0] OP_MUL = 5'd5;
    localparam logic [OPC_W-1:0] OP_DIV = 5'd6;
    localparam logic [OPC_W-1:0] OP_AND = 5'd7;
    localparam logic [OPC_W-1:0] OP_OR  = 5'd8;
    localparam logic [OPC_W-1:0] OP_SHL = 5'd9;
    localparam logic [OPC_W-1:0] OP_SHR = 5'd10;
    localparam logic [OPC_W-1:0] OP_CMP = 5'd11;
    localparam logic [OPC_W-1:0] OP_NOT = 5'd12;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LAUNCH,
        WAIT,
        OUT
    } seq_state_e;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] src_a;
        logic [REG_W-1:0] src_b;
        logic [REG_W-1:0] dest;
        logic [IMM_W-1:0] imm;
    } instr_t;

    function automatic instr_t decode_instr(input logic [31:0] raw);
        instr_t d;
        d.opcode = raw[OPC_LSB +: OPC_W];
        d.src_a  = raw[SRCA_LSB +: REG_W];
        d.src_b  = raw[SRCB_LSB +: REG_W];
        d.dest   = raw[DEST_LSB +: REG_W];
        d.imm    = raw[IMM_LSB +: IMM_W];
        return d;
    endfunction

    function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
        case (op)
            OP_LW, OP_SW, OP_ADD, OP_SUB, OP_MUL, OP_DIV,
            OP_AND, OP_OR, OP_SHL, OP_SHR, OP_CMP, OP_NOT: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    function automatic logic is_mem_op(input logic [OPC_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/alu_timeout_counter.sv
// Cycle counter supervising a launched ALU operation; raises expired once
// the count reaches TIMEOUT_CYC and holds there until cleared.
module alu_timeout_counter #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count_q;

    assign expired = (count_q == CNT_W'(TIMEOUT_CYC));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_exec_sequencer.sv
// Execute-stage sequencer: accepts one instruction, reads the register file,
// launches the ALU with selected operands, supervises completion and hands off.
module alu_exec_sequencer
    import alu_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_instr,
    output logic              rf_rd_en,
    output logic [4:0]        rf_rd_addr_a,
    output logic [4:0]        rf_rd_addr_b,
    input  logic [DWIDTH-1:0] rf_rd_data_a,
    input  logic [DWIDTH-1:0] rf_rd_data_b,
    output logic [4:0]        alu_op,
    output logic [DWIDTH:0]   alu_a,
    output logic [DWIDTH:0]   alu_b,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [DWIDTH-1:0] alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_result,
    output logic [4:0]        out_dest,
    output logic              out_is_load,
    output logic              out_is_store,
    output logic              err_illegal,
    output logic              err_timeout
);

    localparam int OPW = DWIDTH + 1;

    seq_state_e state_q, state_d;
    instr_t     in_dec, instr_q;

    logic accept, capture, timeout_hit;
    logic cnt_clear, cnt_enable, cnt_expired;
    logic launch;

    logic [OPW-1:0]   a_sel, b_sel, a_q, b_q;
    logic [OPC_W-1:0] op_q;

    logic [DWIDTH-1:0] result_q;
    logic [REG_W-1:0]  dest_q;
    logic              load_q, store_q;
    logic              err_illegal_q, err_timeout_q;

    assign in_dec = decode_instr(in_instr[31:0]);
    assign launch = (state_q == LAUNCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        rf_rd_en     = 1'b0;
        rf_rd_addr_a = '0;
        rf_rd_addr_b = '0;
        alu_start    = 1'b0;
        out_valid    = 1'b0;
        accept       = 1'b0;
        capture      = 1'b0;
        timeout_hit  = 1'b0;
        cnt_clear    = 1'b1;
        cnt_enable   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (is_legal_op(in_dec.opcode)) begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                rf_rd_en     = 1'b1;
                rf_rd_addr_a = instr_q.src_a;
                rf_rd_addr_b = instr_q.src_b;
                state_d      = LAUNCH;
            end
            LAUNCH: begin
                // Counting from LAUNCH makes the first WAIT cycle read 1.
                alu_start  = 1'b1;
                cnt_clear  = 1'b0;
                cnt_enable = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                cnt_clear  = 1'b0;
                cnt_enable = 1'b1;
                if (alu_done) begin
                    capture = 1'b1;
                    state_d = OUT;
                end else if (cnt_expired) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    alu_timeout_counter #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .expired(cnt_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q       <= '0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                instr_q <= in_dec;
            end
            err_illegal_q <= accept && !is_legal_op(in_dec.opcode);
            err_timeout_q <= timeout_hit;
        end
    end

    // Memory ops address off srcB plus the sign-extended immediate.
    always_comb begin
        if (is_mem_op(instr_q.opcode)) begin
            a_sel = {1'b0, rf_rd_data_b};
            b_sel = {{(OPW - IMM_W){instr_q.imm[IMM_W-1]}}, instr_q.imm};
        end else begin
            a_sel = {1'b0, rf_rd_data_a};
            b_sel = {1'b0, rf_rd_data_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else if (launch) begin
            a_q  <= a_sel;
            b_q  <= b_sel;
            op_q <= instr_q.opcode;
        end
    end

    // Read data only arrives in LAUNCH, so that cycle bypasses the hold registers.
    assign alu_a  = launch ? a_sel : a_q;
    assign alu_b  = launch ? b_sel : b_q;
    assign alu_op = launch ? instr_q.opcode : op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            dest_q   <= '0;
            load_q   <= 1'b0;
            store_q  <= 1'b0;
        end else if (capture) begin
            result_q <= alu_result;
            dest_q   <= instr_q.dest;
            load_q   <= (instr_q.opcode == OP_LW);
            store_q  <= (instr_q.opcode == OP_SW);
        end
    end

    assign out_result   = result_q;
    assign out_dest     = dest_q;
    assign out_is_load  = load_q;
    assign out_is_store = store_q;
    assign err_illegal  = err_illegal_q;
    assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Self-checking bench for alu_exec_sequencer: register-file and ALU responders,
// directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_exec_sequencer;

    localparam int DW = 32;
    localparam int TO = 64;

    localparam logic [4:0] LW = 5'd0, SW = 5'd1, ADD = 5'd3, SUB = 5'd4, MUL = 5'd5, DIV = 5'd6;
    localparam logic [4:0] AND_ = 5'd7, OR_ = 5'd8, SHL = 5'd9, SHR = 5'd10, CMP = 5'd11, NOT_ = 5'd12;

    logic          clk, rst_n;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_instr;
    logic          rf_rd_en;
    logic [4:0]    rf_rd_addr_a, rf_rd_addr_b;
    logic [DW-1:0] rf_rd_data_a, rf_rd_data_b;
    logic [4:0]    alu_op;
    logic [DW:0]   alu_a, alu_b;
    logic          alu_start, alu_done;
    logic [DW-1:0] alu_result;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_result;
    logic [4:0]    out_dest;
    logic          out_is_load, out_is_store, err_illegal, err_timeout;

    alu_exec_sequencer #(.DWIDTH(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .rf_rd_en(rf_rd_en), .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_dest(out_dest), .out_is_load(out_is_load), .out_is_store(out_is_store),
        .err_illegal(err_illegal), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: data appears the cycle after the read strobe.
    logic [31:0] rf [0:31];
    always @(posedge clk) begin
        if (rf_rd_en) begin
            rf_rd_data_a <= rf[rf_rd_addr_a];
            rf_rd_data_b <= rf[rf_rd_addr_b];
        end
    end

    int n_cmp, n_mis;

    // Per-transaction observations
    int          rd_k, st_k, il_k, to_k, out_first, hs_k;
    int          rd_cnt, st_cnt, il_cnt, to_cnt, out_seen, unstable;
    logic [4:0]  rd_a_addr, rd_b_addr, st_op;
    logic [32:0] st_a, st_b, a_after, b_after;
    logic [31:0] o_res;
    logic [4:0]  o_dest;
    logic        o_ld, o_st;
    logic        rdy_h [0:127];
    logic        ov_h  [0:127];

    function automatic logic [31:0] mk_instr(input logic [4:0] op, input logic [4:0] sa,
                                             input logic [4:0] sb, input logic [16:0] imm);
        return {op, sa, sb, imm};
    endfunction

    // Behavioural ALU used both by the responder and by the expectation model.
    function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            LW, SW, ADD: return a + b;
            SUB:         return a - b;
            MUL:         return a * b;
            DIV:         return (b == 0) ? 32'hFFFF_FFFF : a / b;
            AND_:        return a & b;
            OR_:         return a | b;
            SHL:         return a << b[4:0];
            SHR:         return a >> b[4:0];
            CMP:         return (a < b) ? 32'd1 : 32'd0;
            NOT_:        return ~a;
            default:     return 32'd0;
        endcase
    endfunction

    function automatic logic [32:0] model_a(input logic [4:0] op, input logic [4:0] sa, input logic [4:0] sb);
        return (op == LW || op == SW) ? {1'b0, rf[sb]} : {1'b0, rf[sa]};
    endfunction

    function automatic logic [32:0] model_b(input logic [4:0] op, input logic [4:0] sb, input logic [16:0] imm);
        longint v;
        if (op == LW || op == SW) begin
            v = longint'(imm);
            if (imm >= 17'd65536) v = v - 131072;
            return v[32:0];
        end
        return {1'b0, rf[sb]};
    endfunction

    function automatic bit ready_all(input int lo, input int hi, input logic v);
        for (int i = lo; i <= hi; i++) if (rdy_h[i] !== v) return 1'b0;
        return 1'b1;
    endfunction

    // Offer one instruction and run ncyc cycles after acceptance, acting as ALU and writeback.
    // done_at: cycle index (1 = READ) carrying alu_done, 0 = never; ready_lag: OUT cycles with out_ready low.
    task automatic do_op(input logic [31:0] instr, input int done_at, input int ready_lag, input int ncyc);
        rd_k = -1; st_k = -1; il_k = -1; to_k = -1; out_first = -1; hs_k = -1;
        rd_cnt = 0; st_cnt = 0; il_cnt = 0; to_cnt = 0; out_seen = 0; unstable = 0;
        st_op = 'x; st_a = 'x; st_b = 'x;
        for (int i = 0; i < 128; i++) begin rdy_h[i] = 1'bx; ov_h[i] = 1'bx; end
        @(posedge clk); #1;
        in_valid = 1'b1; in_instr = instr; alu_done = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rdy_h[0] = in_ready;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            in_valid   = 1'b0;
            alu_done   = (k == done_at);
            alu_result = (k == done_at) ? alu_fn(st_op, st_a[31:0], st_b[31:0]) : $urandom;
            out_ready  = (out_seen >= ready_lag);
            @(negedge clk);
            rdy_h[k] = in_ready;
            ov_h[k]  = out_valid;
            if (rf_rd_en) begin
                rd_cnt++;
                if (rd_k < 0) begin rd_k = k; rd_a_addr = rf_rd_addr_a; rd_b_addr = rf_rd_addr_b; end
            end
            if (alu_start) begin
                st_cnt++;
                if (st_k < 0) begin st_k = k; st_a = alu_a; st_b = alu_b; st_op = alu_op; end
            end
            if (st_k >= 0 && k == st_k + 1) begin a_after = alu_a; b_after = alu_b; end
            if (err_illegal) begin il_cnt++; il_k = k; end
            if (err_timeout) begin to_cnt++; to_k = k; end
            if (out_valid) begin
                if (out_seen == 0) begin
                    out_first = k; o_res = out_result; o_dest = out_dest; o_ld = out_is_load; o_st = out_is_store;
                end else if ({out_result, out_dest, out_is_load, out_is_store} !== {o_res, o_dest, o_ld, o_st}) begin
                    unstable++;
                end
                out_seen++;
                if (out_ready && hs_k < 0) hs_k = k;
            end
        end
        alu_done = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_mis++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++;
        if ({rf_rd_en, alu_start, out_valid, err_illegal, err_timeout} !== 5'b0) begin
            n_mis++; $display("FAIL reset_strobes: got %b want 00000", {rf_rd_en, alu_start, out_valid, err_illegal, err_timeout});
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_op, out_result, out_dest, out_is_load, out_is_store, rf_rd_addr_a, rf_rd_addr_b} !== '0) begin
            n_mis++; $display("FAIL reset_buses: alu_a=%h alu_b=%h op=%0d res=%h dest=%0d", alu_a, alu_b, alu_op, out_result, out_dest);
        end
    endtask

    task automatic test_add;
        rf[1] = 32'd5; rf[2] = 32'd7;
        do_op(mk_instr(ADD, 5'd1, 5'd2, {5'd3, 12'd0}), 3, 0, 8);
        n_cmp++;
        if (rd_k !== 1 || rd_cnt !== 1 || rd_a_addr !== 5'd1 || rd_b_addr !== 5'd2) begin
            n_mis++; $display("FAIL add_read: cycle=%0d count=%0d addr=%0d/%0d want cycle 1 count 1 addr 1/2", rd_k, rd_cnt, rd_a_addr, rd_b_addr);
        end
        n_cmp++;
        if (st_k !== 2 || st_cnt !== 1 || st_op !== ADD || st_a !== 33'd5 || st_b !== 33'd7) begin
            n_mis++; $display("FAIL add_launch: cycle=%0d op=%0d a=%h b=%h want cycle 2 op 3 a=5 b=7", st_k, st_op, st_a, st_b);
        end
        n_cmp++;
        if (a_after !== 33'd5 || b_after !== 33'd7) begin
            n_mis++; $display("FAIL add_operand_hold: a=%h b=%h want 5/7", a_after, b_after);
        end
        n_cmp++;
        if (out_first !== 4 || o_res !== 32'd12 || o_dest !== 5'd3 || {o_ld, o_st} !== 2'b00) begin
            n_mis++; $display("FAIL add_out: cycle=%0d res=%0d dest=%0d ld/st=%b%b want cycle 4 res 12 dest 3 00", out_first, o_res, o_dest, o_ld, o_st);
        end
        n_cmp++;
        if (hs_k !== 4 || ov_h[5] !== 1'b0 || !ready_all(1, 4, 1'b0) || rdy_h[5] !== 1'b1) begin
            n_mis++; $display("FAIL add_handoff: hs=%0d ov5=%b rdy5=%b busy_ready_ok=%0d want hs 4 ov5 0 rdy5 1", hs_k, ov_h[5], rdy_h[5], ready_all(1, 4, 1'b0));
        end
    endtask

    task automatic test_lw;
        rf[2] = 32'h100; rf[4] = $urandom;
        do_op(mk_instr(LW, 5'd4, 5'd2, 17'h1FFFC), 3, 0, 8);
        n_cmp++;
        if (st_op !== LW || st_a !== 33'h0_0000_0100 || st_b !== 33'h1_FFFF_FFFC) begin
            n_mis++; $display("FAIL lw_operands: op=%0d a=%h b=%h want 0 / 000000100 / 1fffffffc", st_op, st_a, st_b);
        end
        n_cmp++;
        if ({o_ld, o_st} !== 2'b10 || o_dest !== 5'h1F || o_res !== 32'h0000_00FC) begin
            n_mis++; $display("FAIL lw_out: ld/st=%b%b dest=%0d res=%h want 10 dest 31 res fc", o_ld, o_st, o_dest, o_res);
        end
    endtask

    task automatic test_div_stall;
        rf[5] = 32'd1000; rf[6] = 32'd7;
        do_op(mk_instr(DIV, 5'd5, 5'd6, {5'd9, 12'd0}), 22, 3, 30);
        n_cmp++;
        if (out_first !== 23 || hs_k !== 26 || out_seen !== 4 || ov_h[27] !== 1'b0) begin
            n_mis++; $display("FAIL div_handoff: first=%0d hs=%0d seen=%0d ov27=%b want 23/26/4/0", out_first, hs_k, out_seen, ov_h[27]);
        end
        n_cmp++;
        if (unstable !== 0 || o_res !== 32'd142 || o_dest !== 5'd9) begin
            n_mis++; $display("FAIL div_hold: unstable=%0d res=%0d dest=%0d want 0/142/9", unstable, o_res, o_dest);
        end
        n_cmp++;
        if (!ready_all(1, 26, 1'b0) || rdy_h[27] !== 1'b1) begin
            n_mis++; $display("FAIL div_in_ready: busy_low_ok=%0d rdy27=%b want 1/1", ready_all(1, 26, 1'b0), rdy_h[27]);
        end
    endtask

    task automatic test_illegal;
        logic [4:0] ops [3];
        ops[0] = 5'd13; ops[1] = 5'd2; ops[2] = 5'($urandom_range(14, 31));
        for (int i = 0; i < 3; i++) begin
            do_op(mk_instr(ops[i], 5'($urandom), 5'($urandom), 17'($urandom)), 0, 0, 4);
            n_cmp++;
            if (il_cnt !== 1 || il_k !== 1 || rd_cnt !== 0 || st_cnt !== 0 || to_cnt !== 0 || out_seen !== 0) begin
                n_mis++; $display("FAIL illegal_op%0d: pulses=%0d at=%0d rd=%0d start=%0d to=%0d out=%0d want 1/1/0/0/0/0",
                                  ops[i], il_cnt, il_k, rd_cnt, st_cnt, to_cnt, out_seen);
            end
            n_cmp++;
            if (!ready_all(0, 4, 1'b1)) begin
                n_mis++; $display("FAIL illegal_in_ready_op%0d: in_ready dropped, got 0 want 1", ops[i]);
            end
        end
    endtask

    task automatic test_timeout;
        rf[7] = $urandom; rf[8] = $urandom;
        do_op(mk_instr(MUL, 5'd7, 5'd8, {5'd10, 12'd0}), 0, 0, TO + 6);
        n_cmp++;
        if (to_cnt !== 1 || to_k !== TO + 3 || out_seen !== 0 || st_cnt !== 1) begin
            n_mis++; $display("FAIL timeout_pulse: count=%0d at=%0d out=%0d start=%0d want 1/%0d/0/1", to_cnt, to_k, out_seen, st_cnt, TO + 3);
        end
        n_cmp++;
        if (!ready_all(1, TO + 2, 1'b0) || rdy_h[TO+3] !== 1'b1) begin
            n_mis++; $display("FAIL timeout_in_ready: busy_low_ok=%0d rdy_after=%b want 1/1", ready_all(1, TO + 2, 1'b0), rdy_h[TO+3]);
        end
    endtask

    task automatic test_done_at_limit;
        logic [31:0] exp_res;
        rf[9] = $urandom; rf[10] = $urandom;
        exp_res = alu_fn(MUL, rf[9], rf[10]);
        do_op(mk_instr(MUL, 5'd9, 5'd10, {5'd11, 12'd0}), TO + 2, 0, TO + 8);
        n_cmp++;
        if (to_cnt !== 0 || out_first !== TO + 3 || o_res !== exp_res) begin
            n_mis++; $display("FAIL done_at_limit: to=%0d first=%0d res=%h want 0/%0d/%h", to_cnt, out_first, o_res, TO + 3, exp_res);
        end
    endtask

    task automatic test_random;
        logic [4:0]  op, sa, sb;
        logic [16:0] imm;
        logic [32:0] ea, eb;
        logic [31:0] er;
        int          d, lag;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        for (int it = 0; it < 20; it++) begin
            op = 5'($urandom_range(0, 11));
            if (op >= 5'd2) op = op + 5'd1;
            sa = 5'($urandom); sb = 5'($urandom); imm = 17'($urandom);
            if (it % 4 == 0) rf[sb] = (it % 8 == 0) ? 32'd0 : $urandom_range(0, 40);
            d = 3 + $urandom_range(0, 5); lag = $urandom_range(0, 3);
            ea = model_a(op, sa, sb); eb = model_b(op, sb, imm);
            er = alu_fn(op, ea[31:0], eb[31:0]);
            do_op(mk_instr(op, sa, sb, imm), d, lag, d + lag + 3);
            n_cmp++;
            if (st_op !== op || st_a !== ea || st_b !== eb) begin
                n_mis++; $display("FAIL rand%0d_operands: op=%0d a=%h b=%h want op=%0d a=%h b=%h", it, st_op, st_a, st_b, op, ea, eb);
            end
            n_cmp++;
            if (o_res !== er || o_dest !== imm[16:12] || o_ld !== (op == LW) || o_st !== (op == SW)) begin
                n_mis++; $display("FAIL rand%0d_result: res=%h dest=%0d ld/st=%b%b want res=%h dest=%0d op=%0d", it, o_res, o_dest, o_ld, o_st, er, imm[16:12], op);
            end
            n_cmp++;
            if (out_first !== d + 1 || hs_k !== d + 1 + lag || unstable !== 0 || rdy_h[d+2+lag] !== 1'b1) begin
                n_mis++; $display("FAIL rand%0d_timing: first=%0d hs=%0d unstable=%0d want %0d/%0d/0", it, out_first, hs_k, unstable, d + 1, d + 1 + lag);
            end
        end
    endtask

    task automatic test_reset_mid_wait;
        int bad;
        rf[1] = 32'd5; rf[2] = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b1; in_instr = mk_instr(ADD, 5'd1, 5'd2, {5'd3, 12'd0}); alu_done = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || alu_a !== 33'd5) begin
            n_mis++; $display("FAIL rstwait_pre: in_ready=%b alu_a=%h want 0/5", in_ready, alu_a);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({alu_start, rf_rd_en, out_valid, err_illegal, err_timeout, alu_a, alu_b, alu_op,
             out_result, out_dest, out_is_load, out_is_store} !== '0 || in_ready !== 1'b1) begin
            n_mis++; $display("FAIL rstwait_async: alu_a=%h alu_b=%h op=%0d in_ready=%b want zeros and in_ready 1", alu_a, alu_b, alu_op, in_ready);
        end
        @(negedge clk); #2 rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            alu_done = (k == 0); alu_result = $urandom;
            @(negedge clk);
            if (out_valid !== 1'b0 || err_timeout !== 1'b0 || err_illegal !== 1'b0 || in_ready !== 1'b1 || alu_start !== 1'b0) bad++;
        end
        alu_done = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (bad !== 0) begin
            n_mis++; $display("FAIL rstwait_late_done: %0d bad cycles, want 0", bad);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_mis = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; alu_done = 1'b0; alu_result = '0; out_ready = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        #23 rst_n = 1'b1;
        test_reset;
        test_add;
        test_lw;
        test_div_stall;
        test_illegal;
        test_timeout;
        test_done_at_limit;
        test_random;
        test_reset_mid_wait;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
